imem_responder: RTL

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction memory responder: byte-stream program loader plus a fetch port
// with a one-entry line buffer and a fixed-latency miss path.
module imem_responder #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned WAIT  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  output logic [31:0] imem_data,
  input  logic        fetch_req,
  output logic        fetch_ready,
  input  logic        ld_valid,
  input  logic [7:0]  ld_byte,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        ld_ovf
);

  localparam int unsigned AW = $clog2(DEPTH);

  localparam logic [1:0] S_LOAD = 2'd0;
  localparam logic [1:0] S_IDLE = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  logic [1:0]  state;
  logic [AW:0] wr_ptr;
  logic [1:0]  byte_cnt;
  logic [31:0] asm_word;
  logic [31:0] word_next;
  logic [31:0] mem [DEPTH];

  logic        buf_valid;
  logic [29:0] buf_tag;
  logic [31:0] buf_word;
  logic [29:0] lat_tag;
  logic [2:0]  cnt;
  logic [31:0] rd_word;
  logic        ovf;

  logic        ld_acc;
  logic        ld_wr;
  logic        wr_full;
  logic [29:0] cur_tag;
  logic        hit;
  logic        redirect;
  logic        lat_oob;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^imem_addr[1:0];

  assign cur_tag  = imem_addr[31:2];
  assign ld_acc   = (state == S_LOAD) && ld_valid;
  assign ld_wr    = ld_acc && ((byte_cnt == 2'd3) || ld_last);
  assign wr_full  = (wr_ptr == (AW+1)'(DEPTH));
  assign hit      = buf_valid && (buf_tag == cur_tag);
  assign redirect = fetch_req && (cur_tag != lat_tag);
  assign lat_oob  = |lat_tag[29:AW];
  assign ld_ready = (state == S_LOAD);
  assign ld_ovf   = ovf;

  // asm_word is cleared after every write, so a short final word has zero upper bytes
  always_comb begin
    word_next = asm_word;
    case (byte_cnt)
      2'd0:    word_next[7:0]   = ld_byte;
      2'd1:    word_next[15:8]  = ld_byte;
      2'd2:    word_next[23:16] = ld_byte;
      default: word_next[31:24] = ld_byte;
    endcase
  end

  always_comb begin
    fetch_ready = 1'b0;
    imem_data   = '0;
    case (state)
      S_IDLE: begin
        if (fetch_req && hit) begin
          fetch_ready = 1'b1;
          imem_data   = buf_word;
        end
      end
      S_RESP: begin
        if (fetch_req && !redirect) begin
          fetch_ready = 1'b1;
          imem_data   = rd_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst && ld_wr && !wr_full) begin
      mem[wr_ptr[AW-1:0]] <= word_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_LOAD;
      wr_ptr    <= '0;
      byte_cnt  <= '0;
      asm_word  <= '0;
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_word  <= '0;
      lat_tag   <= '0;
      cnt       <= '0;
      rd_word   <= '0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_acc) begin
            if (wr_full) begin
              ovf <= 1'b1;
            end
            if (ld_wr) begin
              asm_word  <= '0;
              byte_cnt  <= '0;
              buf_valid <= 1'b0;
              if (!wr_full) begin
                wr_ptr <= wr_ptr + 1'b1;
              end
            end else begin
              asm_word <= word_next;
              byte_cnt <= byte_cnt + 1'b1;
            end
            if (ld_last) begin
              state <= S_IDLE;
            end
          end
        end
        S_IDLE: begin
          if (fetch_req && !hit) begin
            lat_tag <= cur_tag;
            cnt     <= 3'(WAIT);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (redirect) begin
            lat_tag <= cur_tag;
            cnt     <= 3'(WAIT);
          end else if (cnt == 3'd0) begin
            rd_word <= lat_oob ? 32'h0 : mem[lat_tag[AW-1:0]];
            state   <= S_RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: begin
          // A redirect in RESP behaves like a fresh miss; the stale word is dropped
          if (redirect) begin
            lat_tag <= cur_tag;
            cnt     <= 3'(WAIT);
            state   <= S_WAIT;
          end else begin
            buf_valid <= 1'b1;
            buf_tag   <= lat_tag;
            buf_word  <= rd_word;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule
